// File: rtl/fir_dq_pkg.sv
// fir_dq_pkg: shared constants and sample type for the FIR decimate/quantise stage.
// Holds default widths, shift, saturation bounds and the signed output sample type.
package fir_dq_pkg;

  localparam int FDQ_IN_W  = 27;
  localparam int FDQ_OUT_W = 12;
  localparam int FDQ_SHIFT = 11;

  localparam int FDQ_SAT_MAX = (2 ** (FDQ_OUT_W - 1)) - 1;
  localparam int FDQ_SAT_MIN = -(2 ** (FDQ_OUT_W - 1));

  typedef logic signed [FDQ_OUT_W-1:0] fdq_sample_t;

endpackage

// File: rtl/fir_dq_if.sv
// fir_dq_if: valid/ready output stream of the quantiser (dout, dout_valid, dout_ready).
// master: drives dout/dout_valid, reads dout_ready; slave: the opposite.
interface fir_dq_if
  import fir_dq_pkg::*;
#(
  parameter int W = FDQ_OUT_W
);

  logic signed [W-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/fir_dq_fifo.sv
// fir_dq_fifo: synchronous FIFO, W bits wide, DEPTH (power of two) entries.
// Ports: push, pop (caller-qualified), din, dout (head), full, empty.
module fir_dq_fifo
  import fir_dq_pkg::*;
#(
  parameter int W     = FDQ_OUT_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  // Extra MSB tells a wrapped writer from an equal reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_decim_quant.sv
// fir_decim_quant: decimate FIR output by DECIM, round/saturate to OUT_WIDTH, buffer in FIFO.
// Ports: clk, rst_n, din/din_valid in; sink (fir_dq_if.master) out; sat_flag, drop_err, sat_cnt.
// Build option: define FIR_DQ_SAT_CNT_EN to build the saturating sat_cnt counter (else tied 0).
module fir_decim_quant
  import fir_dq_pkg::*;
#(
  parameter int IN_WIDTH   = FDQ_IN_W,
  parameter int OUT_WIDTH  = FDQ_OUT_W,
  parameter int SHIFT      = FDQ_SHIFT,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IN_WIDTH-1:0] din,
  input  logic                       din_valid,
  fir_dq_if.master                   sink,
  output logic                       sat_flag,
  output logic                       drop_err,
  output logic [15:0]                sat_cnt
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RW = IN_WIDTH + 1;

  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [RW-1:0] RND     = RW'(2 ** (SHIFT - 1));

  localparam logic signed [RW-1:0] SMAX =
    RW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = ~SMAX;

  logic [PW-1:0]        phase;
  logic                 keep;
  logic [RW-1:0]        sum;
  logic signed [RW-1:0] r;
  logic [OUT_WIDTH-1:0] q;
  logic                 sat;

  logic                 s1_valid;
  logic [OUT_WIDTH-1:0] s1_data;
  logic                 s1_sat;

  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 accept;
  logic                 drop;
  logic [OUT_WIDTH-1:0] fifo_dout;

  assign keep = din_valid && (phase == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (din_valid) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  // One guard bit above din keeps the rounding add from wrapping.
  assign sum = {din[IN_WIDTH-1], din} + RND;
  assign r   = $signed(sum) >>> SHIFT;

  always_comb begin
    sat = 1'b1;
    q   = SMAX[OUT_WIDTH-1:0];
    unique case (1'b1)
      (r > SMAX): begin
        q = SMAX[OUT_WIDTH-1:0];
      end
      (r < SMIN): begin
        q = SMIN[OUT_WIDTH-1:0];
      end
      default: begin
        sat = 1'b0;
        q   = r[OUT_WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data <= q;
        s1_sat  <= sat;
      end
    end
  end

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop    = sink.dout_ready & ~empty;
  assign accept = s1_valid & (~full | pop);
  assign drop   = s1_valid & full & ~pop;

  assign sat_flag = accept & s1_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (drop) begin
      drop_err <= 1'b1;
    end
  end

  fir_dq_fifo #(
    .W     (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (s1_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign sink.dout       = fifo_dout;
  assign sink.dout_valid = ~empty;

`ifdef FIR_DQ_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_flag && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  assign sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fir_decim_quant.sv
// tb_fir_decim_quant: scoreboard bench for fir_decim_quant (DECIM=2, depth 4).
// Directed cases plus randomized traffic against an arithmetic reference model.
module tb_fir_decim_quant;

  localparam int DEC   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int val;
    bit sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [26:0] din = '0;
  logic               din_valid = 1'b0;
  logic               sat_flag;
  logic               drop_err;
  logic [15:0]        sat_cnt;

  fir_dq_if #(.W(12)) bus ();

  fir_decim_quant #(
    .IN_WIDTH   (27),
    .OUT_WIDTH  (12),
    .SHIFT      (11),
    .DECIM      (DEC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sink      (bus.master),
    .sat_flag  (sat_flag),
    .drop_err  (drop_err),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   outstanding = 0;
  int   bph = 0;
  int   exp_sat = 0;
  int   obs_sat = 0;

  bit               prev_v = 0;
  bit               prev_r = 0;
  logic signed [11:0] prev_d = '0;

  function automatic int ref_q(longint x, output bit s);
    longint t;
    longint r;
    t = x + 1024;
    if (t >= 0) r = t / 2048;
    else r = -((-t + 2047) / 2048);
    s = 0;
    if (r > 2047) begin
      r = 2047;
      s = 1;
    end else if (r < -2048) begin
      r = -2048;
      s = 1;
    end
    return int'(r);
  endfunction

  task automatic chk(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: pops expected results whenever the sink takes one.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
      prev_r = 0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", longint'(bus.dout_valid), 1);
        chk("hold_data", longint'(bus.dout), longint'(prev_d));
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0d required none",
                   bus.dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dout", longint'(bus.dout), longint'(e.val));
          outstanding--;
        end
      end
      if (sat_flag) obs_sat++;
      prev_v = bus.dout_valid;
      prev_r = bus.dout_ready;
      prev_d = bus.dout;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(longint x, bit force_acc);
    bit s;
    int v;
    din = x[26:0];
    din_valid = 1'b1;
    if (bph == 0) begin
      v = ref_q(x, s);
      if (force_acc || outstanding < DEPTH) begin
        exp_q.push_back('{val: v, sat: s});
        outstanding++;
        if (s) exp_sat++;
      end
    end
    bph = (bph + 1) % DEC;
    cyc();
    din_valid = 1'b0;
  endtask

  task automatic align();
    while (bph != 0) send(longint'($urandom_range(0, 4095)), 0);
  endtask

  task automatic drain(string name);
    int n;
    bus.dout_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d left required 0",
               name, exp_q.size());
      exp_q.delete();
      outstanding = 0;
    end
    cyc();
    chk({name, "_empty"}, longint'(bus.dout_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    longint lat_in [5];
    longint x;
    logic signed [26:0] rv;
    lat_in = '{1023, 1024, -1025, -1024, 204800};
    bus.dout_ready = 1'b0;
    #2;
    chk("rst_valid", longint'(bus.dout_valid), 0);
    chk("rst_dout", longint'(bus.dout), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    chk("rst_drop_err", longint'(drop_err), 0);
    chk("rst_sat_cnt", longint'(sat_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // Rounding and first-sample latency.
    bus.dout_ready = 1'b1;
    send(lat_in[0], 0);
    chk("lat_edge1", longint'(bus.dout_valid), 0);
    cyc();
    chk("lat_edge2", longint'(bus.dout_valid), 1);
    chk("lat_data", longint'(bus.dout), 0);
    for (int i = 1; i < 5; i++) begin
      align();
      send(lat_in[i], 0);
    end
    drain("round");

    // Saturation.
    align();
    send(4194304, 0);
    chk("sat_flag_hi", longint'(sat_flag), 1);
    align();
    send(-4196352, 0);
    chk("sat_flag_lo", longint'(sat_flag), 1);
    drain("sat");
    chk("sat_pulses", obs_sat, exp_sat);
`ifdef FIR_DQ_SAT_CNT_EN
    chk("sat_cnt", longint'(sat_cnt), 2);
`endif

    // Decimation, back-to-back then with gaps.
    align();
    for (int k = 1; k <= 8; k++) send(k * 2048, 0);
    drain("decim");
    align();
    for (int k = 1; k <= 8; k++) begin
      send(k * 2048, 0);
      repeat ($urandom_range(0, 3)) cyc();
    end
    drain("decim_gap");

    // Full FIFO with simultaneous push and pop.
    bus.dout_ready = 1'b0;
    align();
    for (int k = 1; k <= 4; k++) begin
      send(k * 2048, 0);
      send(0, 0);
    end
    repeat (3) cyc();
    send(5 * 2048, 1);
    bus.dout_ready = 1'b1;
    cyc();
    chk("full_pop_nodrop", longint'(drop_err), 0);
    drain("full_pop");
    chk("full_pop_err", longint'(drop_err), 0);

    // Backpressure with a dropped fifth sample.
    bus.dout_ready = 1'b0;
    align();
    for (int k = 1; k <= 5; k++) begin
      send(k * 2048, 0);
      send(0, 0);
    end
    repeat (3) cyc();
    chk("drop_err_set", longint'(drop_err), 1);
    drain("backpressure");
    chk("drop_err_sticky", longint'(drop_err), 1);

    // Reset with entries queued.
    bus.dout_ready = 1'b0;
    align();
    for (int k = 1; k <= 3; k++) begin
      send(k * 2048, 0);
      send(0, 0);
    end
    repeat (3) cyc();
    chk("pre_rst_valid", longint'(bus.dout_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(bus.dout_valid), 0);
    chk("mid_rst_drop", longint'(drop_err), 0);
    exp_q.delete();
    outstanding = 0;
    bph = 0;
    exp_sat = 0;
    obs_sat = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_valid", longint'(bus.dout_valid), 0);
    bus.dout_ready = 1'b1;
    send(3 * 2048, 0);
    send(9 * 2048, 0);
    drain("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) != 0) begin
          x = longint'($urandom_range(0, 8388608)) - 4194304;
        end else begin
          rv = 27'($urandom());
          x = longint'(rv);
        end
        if (bph == 0 && outstanding >= DEPTH) cyc();
        else send(x, 0);
      end else begin
        cyc();
      end
    end
    drain("random");
    chk("random_sat_pulses", obs_sat, exp_sat);
    chk("random_drop_err", longint'(drop_err), 0);
`ifdef FIR_DQ_SAT_CNT_EN
    chk("random_sat_cnt", longint'(sat_cnt),
        (exp_sat > 65535) ? 65535 : exp_sat);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
